aes_result_uart_tx: RTL and testbench



---
 rtl/aes_tx_pkg.sv | 20 ++
 rtl/aes_tx_fifo.sv | 64 ++++++
 rtl/aes_result_uart_tx.sv | 151 +++++++++++++++
 tb/tb_aes_result_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_tx_pkg.sv
// Shared types and constants for the AES result UART transmitter.
// Optional build macro AES_TX_PARITY_EN adds an even-parity bit per frame.
package aes_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam int   TX_DATA_BITS = 8;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/aes_tx_fifo.sv
// Synchronous FIFO buffering captured result bytes; a pop in the same cycle
// frees a slot so a push while full is still accepted.
module aes_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == {LW{1'b0}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      level  <= {LW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/aes_result_uart_tx.sv
// Captures each rising edge of the AES core's ready flag and sends the result
// byte as a UART frame (8N1, or 8E1 when AES_TX_PARITY_EN is defined).
module aes_result_uart_tx
  import aes_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             res_data,
  input  logic                   res_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_IDX = 3'(TX_DATA_BITS - 1);

  tx_state_t        state;
  logic             ready_q;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       head;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       next_idx;
  logic             bit_done;

  assign push_req = res_ready & ~ready_q;
  assign pop      = (state == IDLE) & ~fifo_empty;
  assign bit_done = (bit_cnt == CNT_LAST);
  assign next_idx = bit_idx + 3'd1;

  aes_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (res_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A capture is lost only when full and no pop makes room this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ready_q  <= res_ready;
      overflow <= overflow | (push_req & fifo_full & ~pop);
    end
  end

  // Transmit FSM; tx and tx_busy change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= TX_IDLE_LVL;
      tx_busy <= 1'b0;
      bit_cnt <= {CNT_W{1'b0}};
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= {CNT_W{1'b0}};
          bit_idx <= 3'd0;
          if (!fifo_empty) begin
            shreg   <= head;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end else begin
            tx      <= TX_IDLE_LVL;
            tx_busy <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= {CNT_W{1'b0}};
            state   <= DATA;
            tx      <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= {CNT_W{1'b0}};
            if (bit_idx == LAST_IDX) begin
`ifdef AES_TX_PARITY_EN
              state <= PARITY;
              tx    <= even_parity(shreg);
`else
              state <= STOP;
              tx    <= TX_IDLE_LVL;
`endif
            end else begin
              bit_idx <= next_idx;
              tx      <= shreg[next_idx];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
`ifdef AES_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            bit_cnt <= {CNT_W{1'b0}};
            state   <= STOP;
            tx      <= TX_IDLE_LVL;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            bit_cnt <= {CNT_W{1'b0}};
            state   <= IDLE;
            tx      <= TX_IDLE_LVL;
            tx_busy <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= TX_IDLE_LVL;
          tx_busy <= 1'b0;
          bit_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_result_uart_tx.sv
// Directed self-checking bench for aes_result_uart_tx at CLKS_PER_BIT=4, DEPTH=4;
// build with AES_TX_PARITY_EN to exercise the parity frame format.
module tb_aes_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef AES_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] res_data;
  logic       res_ready;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  aes_result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Independent UART receiver: samples mid-bit on the falling clock edge.
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_data;
  logic [7:0] rx_q[$];
  logic       rx_par_q[$];
  int         rx_stop_err = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      for (int j = 0; j < 8; j++) begin
        if (mon_cnt == CPB * (j + 1) + CPB / 2) mon_data[j] <= tx;
      end
`ifdef AES_TX_PARITY_EN
      if (mon_cnt == CPB * 9 + CPB / 2) rx_par_q.push_back(tx);
`endif
      if (mon_cnt == CPB * (NBITS - 1) + CPB / 2) begin
        rx_q.push_back(mon_data);
        if (tx !== 1'b1) rx_stop_err <= rx_stop_err + 1;
        mon_active <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_ready = 1'b0;
    res_data  = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_q.delete();
    rx_par_q.delete();
  endtask

  task automatic pulse(input logic [7:0] d);
    res_data  = d;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
  endtask

  task automatic drain(input int lim, output int busy_cycles);
    int k;
    busy_cycles = 0;
    for (k = 0; k < lim; k++) begin
      if (!tx_busy && fifo_level == 3'd0) break;
      tick();
      if (tx_busy) busy_cycles++;
    end
    checks++;
    if (k >= lim) begin
      errors++;
      $display("FAIL drain_timeout: got busy=%0b level=%0d after %0d cycles, required idle", tx_busy, fifo_level, lim);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_single_frame();
    logic exp_bits [11];
    int busy_cnt;
`ifdef AES_TX_PARITY_EN
    exp_bits = '{1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0, 1'b1};
`else
    exp_bits = '{1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1, 1'b1};
`endif
    do_reset();
    tick();
    res_data  = 8'h3C;
    res_ready = 1'b1;
    tick();
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL e0_level: got %0d required 1", fifo_level); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL e0_tx: got %b required 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL e0_busy: got %b required 0", tx_busy); end
    tick();
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL e1_level: got %0d required 0", fifo_level); end
    busy_cnt = 0;
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        checks++;
        if (tx !== exp_bits[b]) begin
          errors++;
          $display("FAIL frame_bit%0d_cyc%0d: got %b required %b", b, c, tx, exp_bits[b]);
        end
        if (tx_busy === 1'b1) busy_cnt++;
        tick();
      end
    end
    checks++; if (busy_cnt != NBITS * CPB) begin errors++; $display("FAIL busy_len: got %0d required %0d", busy_cnt, NBITS * CPB); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL busy_drop: got %b required 0", tx_busy); end
    res_ready = 1'b0;
    repeat (3) tick();
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_rx_count: got %0d required 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h required 3c", rx_q[0]); end
    end
  endtask

  task automatic test_held_level();
    int starts = 0;
    int bc;
    logic prev_busy = 1'b0;
    do_reset();
    res_data  = 8'hA5;
    res_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 2) res_data = 8'hFF;
      if (tx_busy && !prev_busy) starts++;
      prev_busy = tx_busy;
    end
    res_ready = 1'b0;
    drain(100, bc);
    checks++; if (starts != 1) begin errors++; $display("FAIL held_frames: got %0d required 1", starts); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL held_level: got %0d required 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL held_overflow: got %b required 0", overflow); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      errors++; $display("FAIL held_rx: got count %0d first %h required 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_overflow();
    int bc;
    do_reset();
    for (int i = 1; i <= 6; i++) pulse(8'(i));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d required 4", fifo_level); end
    drain(400, bc);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_rx_count: got %0d required 5", rx_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_rx_%0d: got %h required %h", i, rx_q[i], 8'(i + 1)); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    int bc;
    int k;
    logic [7:0] exp_b;
    do_reset();
    for (int i = 1; i <= 5; i++) pulse(8'hA0 + 8'(i));
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fpp_fill: got %0d required 4", fifo_level); end
    for (k = 0; k < 60; k++) begin
      if (!tx_busy) break;
      tick();
    end
    checks++; if (k >= 60) begin errors++; $display("FAIL fpp_idle_timeout: got busy=%b required 0", tx_busy); end
    res_data  = 8'hA6;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fpp_level: got %0d required 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b required 0", overflow); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL fpp_busy: got %b required 1", tx_busy); end
    drain(400, bc);
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL fpp_rx_count: got %0d required 6", rx_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        exp_b = 8'hA1 + 8'(i);
        checks++;
        if (rx_q[i] !== exp_b) begin errors++; $display("FAIL fpp_rx_%0d: got %h required %h", i, rx_q[i], exp_b); end
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    int busy_after = 0;
    do_reset();
    for (int i = 1; i <= 6; i++) pulse(8'h10 + 8'(i));
    repeat (7) tick();
    checks++; if (overflow !== 1'b1 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got ovf=%b busy=%b required 1 1", overflow, tx_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b required 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", tx_busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d required 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b required 0", overflow); end
    rx_q.delete();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_busy !== 1'b0 || tx !== 1'b1) busy_after++;
    end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles required 0", busy_after); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL mid_rx: got %0d frames required 0", rx_q.size()); end
  endtask

`ifdef AES_TX_PARITY_EN
  task automatic test_parity();
    int bc;
    int pre = 0;
    do_reset();
    res_data = 8'h3C; res_ready = 1'b1; tick(); if (tx_busy) pre++;
    res_ready = 1'b0; tick(); if (tx_busy) pre++;
    res_data = 8'h07; res_ready = 1'b1; tick(); if (tx_busy) pre++;
    res_ready = 1'b0; tick(); if (tx_busy) pre++;
    drain(200, bc);
    checks++; if (pre + bc != 88) begin errors++; $display("FAIL par_len: got %0d busy cycles required 88", pre + bc); end
    checks++; if (rx_par_q.size() != 2) begin errors++; $display("FAIL par_count: got %0d required 2", rx_par_q.size()); end
    else begin
      checks++; if (rx_par_q[0] !== 1'b0) begin errors++; $display("FAIL par_3c: got %b required 0", rx_par_q[0]); end
      checks++; if (rx_par_q[1] !== 1'b1) begin errors++; $display("FAIL par_07: got %b required 1", rx_par_q[1]); end
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    res_ready = 1'b0;
    res_data = 8'h00;
    test_reset();
    test_single_frame();
    test_held_level();
    test_overflow();
    test_full_push_pop();
    test_mid_frame_reset();
`ifdef AES_TX_PARITY_EN
    test_parity();
`endif
    checks++; if (rx_stop_err != 0) begin errors++; $display("FAIL stop_bits: got %0d bad stop bits required 0", rx_stop_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
